round_timer_ctrl: RTL and testbench

ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

---
 rtl/round_timer_ctrl.sv | 145 ++++++++++++++
 tb/tb_round_timer_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/round_timer_ctrl.sv
// Quiz round countdown timer with BCD seconds display and pause/abort control.
// Optional build macro ROUND_TIMER_BONUS_EN adds BONUS_ONES seconds per correct answer.
module round_timer_ctrl #(
    parameter int unsigned PRESET_TENS = 3,
    parameter int unsigned PRESET_ONES = 0,
    parameter int unsigned BONUS_ONES  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       correct,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       count_enable,
    output logic       timeout,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam logic [3:0] P_T = 4'(PRESET_TENS);
    localparam logic [3:0] P_O = 4'(PRESET_ONES);

    state_t     state, state_n;
    logic [3:0] t_n, o_n;
    logic [3:0] dec_t, dec_o;
    logic [3:0] rt, ro;
    logic       to_n;

    // BCD add of the bonus with carry into tens, clamped at 99
    function automatic logic [7:0] add_bonus(input logic [3:0] t, input logic [3:0] o);
        logic [4:0] s;
        logic [4:0] tt;
        s  = {1'b0, o} + 5'(BONUS_ONES);
        tt = {1'b0, t};
        if (s > 5'd9) begin
            s  = s - 5'd10;
            tt = tt + 5'd1;
        end
        if (tt > 5'd9) return 8'h99;
        return {tt[3:0], s[3:0]};
    endfunction

    always_comb begin
        dec_t = secs_tens;
        dec_o = secs_ones;
        if (one_sec_in) begin
            if (secs_ones != 4'd0) begin
                dec_o = secs_ones - 4'd1;
            end else if (secs_tens != 4'd0) begin
                dec_o = 4'd9;
                dec_t = secs_tens - 4'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        t_n     = secs_tens;
        o_n     = secs_ones;
        to_n    = 1'b0;
        rt      = secs_tens;
        ro      = secs_ones;
        if (abort) begin
            state_n = IDLE;
            t_n     = P_T;
            o_n     = P_O;
        end else begin
            unique case (state)
                IDLE: begin
                    t_n = P_T;
                    o_n = P_O;
                    if (start) state_n = RUN;
                end
                RUN: begin
                    rt = dec_t;
                    ro = dec_o;
`ifdef ROUND_TIMER_BONUS_EN
                    if (correct) {rt, ro} = add_bonus(rt, ro);
`endif
                    t_n = rt;
                    o_n = ro;
                    if (one_sec_in && rt == 4'd0 && ro == 4'd0) begin
                        state_n = EXPIRED;
                        to_n    = 1'b1;
                    end else if (pause) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: begin
`ifdef ROUND_TIMER_BONUS_EN
                    if (correct) {rt, ro} = add_bonus(rt, ro);
`endif
                    t_n = rt;
                    o_n = ro;
                    if (!pause) state_n = RUN;
                end
                EXPIRED: begin
                    t_n = 4'd0;
                    o_n = 4'd0;
                    if (start) begin
                        state_n = RUN;
                        t_n     = P_T;
                        o_n     = P_O;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifndef ROUND_TIMER_BONUS_EN
    logic unused_correct;
    logic [7:0] unused_bonus;
    assign unused_correct = correct;
    assign unused_bonus   = add_bonus(4'd0, 4'd0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            secs_tens    <= P_T;
            secs_ones    <= P_O;
            timeout      <= 1'b0;
            count_enable <= 1'b0;
        end else begin
            state        <= state_n;
            secs_tens    <= t_n;
            secs_ones    <= o_n;
            timeout      <= to_n;
            count_enable <= (state_n == RUN);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl: stimulus queues expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_round_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_sec_in, start, pause, abort, correct;
    logic [3:0] secs_tens, secs_ones;
    logic       count_enable, timeout;
    logic [1:0] state_out;

    int total = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       ce;
        logic       to;
        logic [1:0] st;
        string      nm;
    } exp_t;

    exp_t q[$];

    round_timer_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .one_sec_in  (one_sec_in),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .correct     (correct),
        .secs_tens   (secs_tens),
        .secs_ones   (secs_ones),
        .count_enable(count_enable),
        .timeout     (timeout),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] t, input logic [3:0] o,
                       input logic ce, input logic to, input logic [1:0] st);
        total++;
        if (secs_tens !== t || secs_ones !== o || count_enable !== ce ||
            timeout !== to || state_out !== st) begin
            fails++;
            $display("FAIL %s: got %h%h ce=%b to=%b st=%b, want %h%h ce=%b to=%b st=%b",
                     nm, secs_tens, secs_ones, count_enable, timeout, state_out,
                     t, o, ce, to, st);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, e.t, e.o, e.ce, e.to, e.st);
        end
    end

    task automatic step(input logic tk, input logic sr, input logic ps,
                        input logic ab, input logic cr, input int v,
                        input logic [1:0] s, input logic to, input string nm);
        exp_t e;
        @(negedge clk);
        one_sec_in = tk;
        start      = sr;
        pause      = ps;
        abort      = ab;
        correct    = cr;
        e.t  = 4'(v / 10);
        e.o  = 4'(v % 10);
        e.ce = (s == 2'b01);
        e.to = to;
        e.st = s;
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        one_sec_in = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
        correct    = 1'b0;
        #12;
        chk("reset", 4'd3, 4'd0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "start");
        for (int v = 29; v >= 1; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick");
        step(1, 0, 0, 0, 0, 0, 2'b11, 1, "expire");
        step(0, 0, 0, 0, 0, 0, 2'b11, 0, "exp_hold");
        step(1, 0, 0, 0, 1, 0, 2'b11, 0, "exp_ignore");
        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "restart");

        for (int v = 29; v >= 25; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick2");
        step(0, 0, 1, 0, 0, 25, 2'b10, 0, "pause");
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, 25, 2'b10, 0, "pause_hold");
        step(0, 1, 1, 0, 0, 25, 2'b10, 0, "pause_start");
        step(0, 0, 0, 0, 0, 25, 2'b01, 0, "resume");
        step(1, 0, 0, 0, 0, 24, 2'b01, 0, "resume_tick");
        step(1, 0, 1, 0, 0, 23, 2'b10, 0, "pause_tick");
        step(0, 0, 0, 0, 0, 23, 2'b01, 0, "resume2");
        for (int v = 22; v >= 17; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick3");
        step(1, 1, 1, 1, 1, 30, 2'b00, 0, "abort");
        step(1, 0, 0, 0, 0, 30, 2'b00, 0, "idle_tick");
        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "start2");
        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "run_start");
        for (int v = 29; v >= 12; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick4");
`ifdef ROUND_TIMER_BONUS_EN
        step(0, 0, 0, 0, 1, 17, 2'b01, 0, "correct");
`else
        step(0, 0, 0, 0, 1, 12, 2'b01, 0, "correct_ign");
`endif

        step(0, 0, 0, 1, 0, 30, 2'b00, 0, "abort2");
        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "start3");
        for (int v = 29; v >= 14; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick5");
        @(negedge clk);
        one_sec_in = 1'b0;
        reset      = 1'b0;
        #2;
        chk("reset_mid", 4'd3, 4'd0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("reset_hold", 4'd3, 4'd0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        step(0, 1, 0, 0, 0, 30, 2'b01, 0, "start_after_rst");

`ifdef ROUND_TIMER_BONUS_EN
        for (int v = 29; v >= 1; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick6");
        step(1, 0, 0, 0, 1, 5, 2'b01, 0, "tick_bonus");
        for (int v = 4; v >= 2; v--) step(1, 0, 0, 0, 0, v, 2'b01, 0, "tick7");
        for (int k = 1; k <= 19; k++) step(0, 0, 0, 0, 1, 2 + 5 * k, 2'b01, 0, "bonus");
        step(0, 0, 0, 0, 1, 99, 2'b01, 0, "bonus_sat");
        step(0, 0, 1, 0, 1, 99, 2'b10, 0, "bonus_pause");
`endif

        @(negedge clk);
        one_sec_in = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
        correct    = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
